// File: rtl/reg_dump_ctrl.sv
// Register-file dump controller: walks FIRST_ADDR..LAST_ADDR through an async read
// port and streams each word out over a valid/ready handshake.
module reg_dump_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIRST_ADDR = 0,
  parameter int LAST_ADDR  = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, FIN} state_t;

  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_ADDR);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              at_last;

  assign at_last = (cnt == LAST);
  assign rf_addr = cnt;

  // NOTE: all state and outputs update with non-blocking assignments so every
  // branch below reads the pre-edge values, exactly as the hardware does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= FIRST;
      dump_valid <= 1'b0;
      dump_last  <= 1'b0;
      dump_data  <= '0;
      dump_addr  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // start wins over a simultaneous abort; abort is meaningless here
          if (start) begin
            cnt   <= FIRST;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            dump_data  <= rf_rdata;
            dump_addr  <= cnt;
            dump_valid <= 1'b1;
            dump_last  <= at_last;
            state      <= SEND;
          end
        end
        SEND: begin
          if (abort) begin
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (dump_ready) begin
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            if (at_last) begin
              busy  <= 1'b0;
              state <= FIN;
            end else begin
              // increment only below LAST, so the counter can never wrap
              cnt   <= cnt + 1'b1;
              state <= LOAD;
            end
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Directed bench for reg_dump_ctrl: full dumps with stall, restart poke, abort and
// mid-dump reset on the default instance, plus a two-word range instance.
module tb_reg_dump_ctrl;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, ready = 1'b0;
  logic [4:0]  rf_addr, dump_addr;
  logic [31:0] rf_rdata, dump_data;
  logic        dump_valid, dump_last, busy, done;

  logic        start2 = 1'b0, abort2 = 1'b0, ready2 = 1'b1;
  logic [4:0]  rf_addr2, dump_addr2;
  logic [31:0] rf_rdata2, dump_data2;
  logic        dump_valid2, dump_last2, busy2, done2;

  logic [31:0] rf_mem [32];
  int          cyc = 0;
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial for (int i = 0; i < 32; i++) rf_mem[i] = BASE + 32'(i);
  assign rf_rdata  = rf_mem[rf_addr];
  assign rf_rdata2 = rf_mem[rf_addr2];

  reg_dump_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rf_addr(rf_addr), .rf_rdata(rf_rdata),
    .dump_valid(dump_valid), .dump_ready(ready), .dump_data(dump_data),
    .dump_addr(dump_addr), .dump_last(dump_last), .busy(busy), .done(done)
  );

  reg_dump_ctrl #(.FIRST_ADDR(30), .LAST_ADDR(31)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .rf_addr(rf_addr2), .rf_rdata(rf_rdata2),
    .dump_valid(dump_valid2), .dump_ready(ready2), .dump_data(dump_data2),
    .dump_addr(dump_addr2), .dump_last(dump_last2), .busy(busy2), .done(done2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full 0..31 dump from IDLE; optional stall on one address and a start poke while busy.
  task automatic dump_all(input string tag, input int stall_addr, input int stall_n,
                          input int poke_addr, input int exp_cyc);
    int exp_addr = 0, beats = 0, dones = 0, stalls = 0, t0, dcyc = -1;
    bit poked = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    for (int i = 0; i < exp_cyc + 10; i++) begin
      start = 1'b0;
      ready = 1'b1;
      if (done) begin
        dones++;
        if (dcyc < 0) dcyc = cyc - t0;
      end
      if (dump_valid) begin
        if (int'(dump_addr) == stall_addr && stalls < stall_n) begin
          ready = 1'b0;
          stalls++;
          check({tag, "_stall_addr"}, dump_addr, 64'(stall_addr));
          check({tag, "_stall_data"}, dump_data, BASE + 32'(stall_addr));
        end else begin
          check({tag, "_addr"}, dump_addr, 64'(exp_addr));
          check({tag, "_data"}, dump_data, BASE + 32'(exp_addr));
          check({tag, "_last"}, dump_last, (exp_addr == 31));
          exp_addr++;
          beats++;
        end
        if (!poked && int'(dump_addr) == poke_addr) begin
          start = 1'b1;
          poked = 1;
        end
      end
      @(negedge clk);
    end
    ready = 1'b0;
    check({tag, "_beats"}, beats, 32);
    check({tag, "_dones"}, dones, 1);
    check({tag, "_done_cyc"}, dcyc, exp_cyc);
    check({tag, "_stalls"}, stalls, stall_n);
    check({tag, "_busy_end"}, busy, 1'b0);
  endtask

  // Step with ready high until the given address is presented (not yet accepted).
  task automatic run_to_addr(input string tag, input int a);
    bit hit = 0;
    ready = 1'b1;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (dump_valid && int'(dump_addr) == a) hit = 1;
      else @(negedge clk);
    end
    check({tag, "_reach"}, hit, 1'b1);
  endtask

  initial begin
    int beats2, dones2, t0, dcyc2;
    bit saw_done;

    // Reset state
    #12;
    check("rst_valid", dump_valid, 1'b0);
    check("rst_last", dump_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_data", dump_data, 32'h0);
    check("rst_addr", dump_addr, 5'd0);
    check("rst_rf_addr", rf_addr, 5'd0);
    check("rst_rf_addr2", rf_addr2, 5'd30);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain full dump, then one with a 5-cycle stall on addr 7, then a start poke at addr 3
    dump_all("full", -1, 0, -1, 65);
    dump_all("stall", 7, 5, -1, 70);
    dump_all("poke", -1, 0, 3, 65);

    // Abort during SEND of addr 12 with ready also high: abort wins, no done
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_to_addr("abort", 12);
    abort = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    ready = 1'b0;
    check("abort_valid", dump_valid, 1'b0);
    check("abort_last", dump_last, 1'b0);
    check("abort_busy", busy, 1'b0);
    saw_done = done;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      saw_done |= done;
    end
    check("abort_no_done", saw_done, 1'b0);
    dump_all("after_abort", -1, 0, -1, 65);

    // Async reset mid-dump at addr 20, observed between clock edges
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_to_addr("rst_mid", 20);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", dump_valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_data", dump_data, 32'h0);
    check("rst_mid_addr", dump_addr, 5'd0);
    check("rst_mid_rf_addr", rf_addr, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      saw_done |= done | busy | dump_valid;
    end
    check("rst_mid_idle", saw_done, 1'b0);
    dump_all("after_rst", -1, 0, -1, 65);

    // Narrow range instance: addresses 30 and 31 only
    beats2 = 0;
    dones2 = 0;
    dcyc2 = -1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 12; i++) begin
      if (done2) begin
        dones2++;
        if (dcyc2 < 0) dcyc2 = cyc - t0;
      end
      if (dump_valid2) begin
        check("r2_addr", dump_addr2, 64'(30 + beats2));
        check("r2_data", dump_data2, BASE + 32'(30 + beats2));
        check("r2_last", dump_last2, (beats2 == 1));
        beats2++;
      end
      @(negedge clk);
    end
    check("r2_beats", beats2, 2);
    check("r2_dones", dones2, 1);
    check("r2_done_cyc", dcyc2, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
